// File: rtl/alu_pkg.sv
// Shared encodings for alu_pipe: op codes, pipeline states and the flag bundle.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LSL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_MULB  = 2'd2
    } state_t;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

    // Flags describing out == 0 after reset.
    localparam flags_t FLAGS_RESET = '{z: 1'b1, n: 1'b0, c: 1'b0, v: 1'b0};

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier, one partial product per cycle, low WIDTH bits kept.
// Only compiled when ALU_PIPE_MUL_EN is defined.
`ifdef ALU_PIPE_MUL_EN
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [CW-1:0]    count_reg;
    logic             busy_reg;

    // product already includes the current step so done can hand it off on the last cycle.
    assign product = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign done    = busy_reg && (count_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            count_reg  <= '0;
            busy_reg   <= 1'b0;
        end else if (start) begin
            mcand_reg  <= a;
            mplier_reg <= b;
            acc_reg    <= '0;
            count_reg  <= '0;
            busy_reg   <= 1'b1;
        end else if (busy_reg) begin
            acc_reg    <= product;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg + CW'(1);
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides and Z/N/C/V flags.
// Define ALU_PIPE_MUL_EN to make op 111 a WIDTH-cycle shift-add multiply.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic [2:0]       ALUop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);
    state_t           state_reg, state_next;
    logic [WIDTH-1:0] out_reg, out_next;
    flags_t           flags_reg, flags_next;

    logic [WIDTH:0]   add_wide, sub_wide;
    logic [WIDTH-1:0] res;
    logic             res_c, res_v;
    logic             accept;

`ifdef ALU_PIPE_MUL_EN
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mul_start),
        .a       (Ain),
        .b       (Bin),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    // Single-cycle op decode; carry and overflow come from the WIDTH+1 bit sums.
    always_comb begin
        add_wide = {1'b0, Ain} + {1'b0, Bin};
        sub_wide = {1'b0, Ain} + {1'b0, ~Bin} + {{WIDTH{1'b0}}, 1'b1};
        res      = '0;
        res_c    = 1'b0;
        res_v    = 1'b0;
        case (ALUop)
            OP_ADD: begin
                res   = add_wide[WIDTH-1:0];
                res_c = add_wide[WIDTH];
                res_v = (Ain[WIDTH-1] == Bin[WIDTH-1]) && (add_wide[WIDTH-1] != Ain[WIDTH-1]);
            end
            OP_SUB: begin
                res   = sub_wide[WIDTH-1:0];
                res_c = sub_wide[WIDTH];
                res_v = (Ain[WIDTH-1] != Bin[WIDTH-1]) && (sub_wide[WIDTH-1] != Ain[WIDTH-1]);
            end
            OP_AND:  res = Ain & Bin;
            OP_NOT:  res = ~Bin;
            OP_OR:   res = Ain | Bin;
            OP_XOR:  res = Ain ^ Bin;
            OP_LSL:  res = Ain << Bin[SHW-1:0];
            default: res = '0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        out_next   = out_reg;
        flags_next = flags_reg;
        in_ready   = (state_reg == ST_EMPTY) || ((state_reg == ST_FULL) && out_ready);
        out_valid  = (state_reg == ST_FULL);
        accept     = in_valid && in_ready;
`ifdef ALU_PIPE_MUL_EN
        mul_start  = 1'b0;
`endif
        if (accept) begin
`ifdef ALU_PIPE_MUL_EN
            if (ALUop == OP_MUL) begin
                state_next = ST_MULB;
                mul_start  = 1'b1;
            end else begin
                state_next = ST_FULL;
                out_next   = res;
                flags_next = '{z: (res == '0), n: res[WIDTH-1], c: res_c, v: res_v};
            end
`else
            state_next = ST_FULL;
            out_next   = res;
            flags_next = '{z: (res == '0), n: res[WIDTH-1], c: res_c, v: res_v};
`endif
        end else if ((state_reg == ST_FULL) && out_ready) begin
            state_next = ST_EMPTY;
        end
`ifdef ALU_PIPE_MUL_EN
        if ((state_reg == ST_MULB) && mul_done) begin
            state_next = ST_FULL;
            out_next   = mul_product;
            flags_next = '{z: (mul_product == '0), n: mul_product[WIDTH-1], c: 1'b0, v: 1'b0};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= ST_EMPTY;
            out_reg   <= '0;
            flags_reg <= FLAGS_RESET;
        end else begin
            state_reg <= state_next;
            out_reg   <= out_next;
            flags_reg <= flags_next;
        end
    end

    assign out = out_reg;
    assign Z   = flags_reg.z;
    assign N   = flags_reg.n;
    assign C   = flags_reg.c;
    assign V   = flags_reg.v;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus a randomized
// handshake run scored against an arithmetic reference model.
module tb_alu_pipe;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] Ain = '0;
    logic [W-1:0] Bin = '0;
    logic [2:0]   ALUop = 3'd0;
    logic         in_ready, out_valid, Z, N, C, V;
    logic [W-1:0] out;

    int checks = 0;
    int passed = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Ain       (Ain),
        .Bin       (Bin),
        .ALUop     (ALUop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .Z         (Z),
        .N         (N),
        .C         (C),
        .V         (V)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference result {out, Z, N, C, V} from integer arithmetic on the operands.
    function automatic logic [W+3:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint ua, ub, sa, sb, r, s;
        longint modv;
        logic [W-1:0] rv;
        logic c, v;
        modv = longint'(1) << W;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[W-1] ? ua - modv : ua;
        sb = b[W-1] ? ub - modv : ub;
        c = 1'b0;
        v = 1'b0;
        r = 0;
        case (op)
            3'd0: begin r = ua + ub; c = (r >= modv); s = sa + sb; v = (s >= modv / 2) || (s < -(modv / 2)); end
            3'd1: begin r = ua - ub + modv; c = (ua >= ub); s = sa - sb; v = (s >= modv / 2) || (s < -(modv / 2)); end
            3'd2: r = longint'(a & b);
            3'd3: r = longint'(~b);
            3'd4: r = longint'(a | b);
            3'd5: r = longint'(a ^ b);
            3'd6: r = ua * (longint'(1) << (ub % W));
`ifdef ALU_PIPE_MUL_EN
            default: r = ua * ub;
`else
            default: r = 0;
`endif
        endcase
        rv = W'(r % modv);
        return {rv, (rv == '0), rv[W-1], c, v};
    endfunction

    task automatic test_reset();
        logic [W+5:0] got;
        reset_n = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ALUop = 3'($urandom_range(0, 6));
            Ain = W'($urandom);
            Bin = W'($urandom);
            step();
        end
        reset_n = 1'b1;
        in_valid = 1'b0;
        #1;
        got = {in_ready, out_valid, out, Z, N, C, V};
        checks++;
        if (got !== {1'b1, 1'b0, 16'h0000, 4'b1000}) $display("FAIL reset got=%h exp=%h", got, {1'b1, 1'b0, 16'h0000, 4'b1000});
        else passed++;
        $display("txn reset in_ready=%b out_valid=%b out=%h", in_ready, out_valid, out);
    endtask

    task automatic test_add_overflow();
        logic [W+4:0] got;
        in_valid = 1'b1; out_ready = 1'b1; Ain = 16'h7FFF; Bin = 16'h0001; ALUop = 3'b000;
        step();
        in_valid = 1'b0;
        got = {out_valid, out, Z, N, C, V};
        checks++;
        if (got !== {1'b1, 16'h8000, 4'b0101}) $display("FAIL add_ovf got=%h exp=%h", got, {1'b1, 16'h8000, 4'b0101});
        else passed++;
        $display("txn add 7fff+0001 out=%h ZNCV=%b%b%b%b", out, Z, N, C, V);
        step();
    endtask

    task automatic test_back_to_back();
        logic [W+4:0] got;
        in_valid = 1'b1; out_ready = 1'b1; Ain = 16'h1234; Bin = 16'h1234; ALUop = 3'b001;
        step();
        Ain = 16'hF0F0; Bin = 16'h0FF0; ALUop = 3'b010;
        got = {out_valid, out, Z, N, C, V};
        checks++;
        if (got !== {1'b1, 16'h0000, 4'b1010}) $display("FAIL sub_zero got=%h exp=%h", got, {1'b1, 16'h0000, 4'b1010});
        else passed++;
        $display("txn sub 1234-1234 out=%h ZNCV=%b%b%b%b", out, Z, N, C, V);
        step();
        in_valid = 1'b0;
        got = {out_valid, out, Z, N, C, V};
        checks++;
        if (got !== {1'b1, 16'h00F0, 4'b0000}) $display("FAIL and_b2b got=%h exp=%h", got, {1'b1, 16'h00F0, 4'b0000});
        else passed++;
        $display("txn and f0f0&0ff0 out=%h ZNCV=%b%b%b%b", out, Z, N, C, V);
        step();
        checks++;
        if (out_valid !== 1'b0) $display("FAIL drain out_valid=%b exp=0", out_valid);
        else passed++;
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; out_ready = 1'b0; Ain = 16'h5555; Bin = 16'h00FF; ALUop = 3'b011;
        step();
        Ain = 16'h0001; Bin = 16'h0002; ALUop = 3'b000;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({in_ready, out_valid, out, Z, N} !== {1'b0, 1'b1, 16'hFF00, 2'b01})
                $display("FAIL hold%0d got in_ready=%b out_valid=%b out=%h ZN=%b%b exp 0 1 ff00 01", i, in_ready, out_valid, out, Z, N);
            else passed++;
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL release in_ready=%b exp=1", in_ready);
        else passed++;
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out} !== {1'b1, 16'h0003}) $display("FAIL after_bp got=%b/%h exp=1/0003", out_valid, out);
        else passed++;
        $display("txn not 00ff held, then add 1+2 out=%h", out);
        step();
    endtask

    task automatic test_lsl();
        in_valid = 1'b1; out_ready = 1'b1; Ain = 16'h0003; Bin = 16'h0004; ALUop = 3'b110;
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out, Z, N, C, V} !== {1'b1, 16'h0030, 4'b0000})
            $display("FAIL lsl got=%b/%h/%b%b%b%b exp=1/0030/0000", out_valid, out, Z, N, C, V);
        else passed++;
        $display("txn lsl 0003<<4 out=%h", out);
        step();
    endtask

`ifdef ALU_PIPE_MUL_EN
    task automatic test_mul();
        int edges;
        int ready_bad;
        in_valid = 1'b1; out_ready = 1'b1; Ain = 16'd300; Bin = 16'd300; ALUop = 3'b111;
        step();
        in_valid = 1'b0;
        edges = 1;
        ready_bad = 0;
        while (!out_valid && edges < 40) begin
            if (in_ready !== 1'b0) ready_bad++;
            step();
            edges++;
        end
        checks++;
        if (ready_bad != 0) $display("FAIL mul_in_ready high_cycles=%0d exp=0", ready_bad);
        else passed++;
        checks++;
        if (edges != 17) $display("FAIL mul_latency edges=%0d exp=17", edges);
        else passed++;
        checks++;
        if ({out_valid, out, Z, N, C, V} !== {1'b1, 16'h5F90, 4'b0000})
            $display("FAIL mul_result got=%b/%h/%b%b%b%b exp=1/5f90/0000", out_valid, out, Z, N, C, V);
        else passed++;
        $display("txn mul 300*300 out=%h edges=%0d", out, edges);
        step();
        in_valid = 1'b1; Ain = 16'd7; Bin = 16'd9; ALUop = 3'b111;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({in_ready, out_valid} !== 2'b10) $display("FAIL mul_reset cyc=%0d in_ready=%b out_valid=%b exp 1 0", i, in_ready, out_valid);
            else passed++;
            step();
        end
        $display("txn mul aborted by reset");
    endtask
`else
    task automatic test_mul();
        in_valid = 1'b1; out_ready = 1'b1; Ain = 16'd300; Bin = 16'd300; ALUop = 3'b111;
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out, Z, N, C, V} !== {1'b1, 16'h0000, 4'b1000})
            $display("FAIL mul_off got=%b/%h/%b%b%b%b exp=1/0000/1000", out_valid, out, Z, N, C, V);
        else passed++;
        $display("txn op111 without multiplier out=%h", out);
        step();
    endtask
`endif

    task automatic test_random();
        bit           mv;
        logic [W+3:0] mval;
        bit           acc;
        int           n;
        mv = 1'b0;
        mval = '0;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
`ifdef ALU_PIPE_MUL_EN
            ALUop = 3'($urandom_range(0, 6));
`else
            ALUop = 3'($urandom_range(0, 7));
`endif
            Ain = W'($urandom);
            Bin = W'($urandom);
            #1;
            checks++;
            if (out_valid !== mv) $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, out_valid, mv);
            else passed++;
            if (mv) begin
                checks++;
                if ({out, Z, N, C, V} !== mval) $display("FAIL rnd_data cyc=%0d got=%h exp=%h", i, {out, Z, N, C, V}, mval);
                else passed++;
            end
            checks++;
            if (in_ready !== (!mv || out_ready)) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, in_ready, (!mv || out_ready));
            else passed++;
            acc = in_valid && (!mv || out_ready);
            if (acc) begin
                mv = 1'b1;
                mval = ref_op(ALUop, Ain, Bin);
                $display("txn rnd%0d op=%0d a=%h b=%h exp=%h", n, ALUop, Ain, Bin, mval);
                n++;
            end else if (out_ready) begin
                mv = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_back_to_back();
        test_backpressure();
        test_lsl();
        test_mul();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor of the datapath ALU.
- Accepts one operation per cycle over a valid/ready handshake and returns a registered result plus status flags (Z, N, C, V).
- Sits between the register-file read ports and the writeback mux, so that the controller FSM can stall on back-pressure.
- Widens the op set to 8 ops; an optional multi-cycle multiply is added by macro.

Parameters:
WIDTH, 16, datapath width in bits (must be >= 4)
SHW, $clog2(WIDTH), shift-amount width taken from Bin[SHW-1:0]

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous, active-low reset; sampled on rising edge of clk
in_valid  input  1  operands/op valid
in_ready  output  1  block can accept operands this cycle
Ain  input  WIDTH  operand A
Bin  input  WIDTH  operand B
ALUop  input  3  operation select
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result this cycle
out  output  WIDTH  result
Z  output  1  result == 0
N  output  1  result MSB
C  output  1  carry-out (ADD), not-borrow (SUB); 0 for other ops
V  output  1  signed overflow (ADD/SUB); 0 for other ops

Behaviour:
- Reset (reset_n low at a clk edge): state=EMPTY; out_valid=0, out=0, Z=1, N=0, C=0, V=0. Reset overrides any in-flight op, including multiply; the op is discarded.
- Ops (ALUop):
  - 000 ADD A+B
  - 001 SUB A-B (A+~B+1)
  - 010 AND
  - 011 NOT B
  - 100 OR
  - 101 XOR
  - 110 LSL A by Bin[SHW-1:0], zero fill
  - 111 MUL (see Optional Feature)
- All arithmetic is modulo 2^WIDTH. C and V are computed at WIDTH+1 bits.
- State EMPTY: in_ready=1, out_valid=0.
- State FULL: out_valid=1; out and flags are held stable until out_ready=1.
- State MULB: only exists with the macro; in_ready=0, out_valid=0.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - in_ready = (state==EMPTY) | (state==FULL & out_ready). This is combinational from out_ready, giving full throughput.
- Latency: single-cycle ops register on the accepting edge; out_valid=1 on the following cycle.
- Transitions:
  - EMPTY + accept(non-MUL) -> FULL.
  - FULL + out_ready & accept(non-MUL) -> FULL with the new result (back-to-back).
  - FULL + out_ready & no accept -> EMPTY.
  - FULL + !out_ready -> FULL; inputs ignored, in_ready=0.
- Flags (Z, N, C, V) are registered together with out and always describe the out value currently presented.

Optional Feature:
- Macro: ALU_PIPE_MUL_EN
- Defined:
  - ALUop 111 is a shift-add multiply; the low WIDTH bits of A*B are returned.
  - Accept -> MULB; multiply takes exactly WIDTH cycles in MULB, then FULL.
  - Total latency is WIDTH+1 edges from accept to out_valid.
  - Flags: C=0, V=0.
  - Iteration counter and partial-product registers reset with reset_n.
- Undefined:
  - ALUop 111 is accepted with single-cycle latency and returns out=0 (Z=1, N=0, C=0, V=0).
  - No MULB state is present.

Decomposition:
- Shared package alu_pkg:
  - ALUop encodings as localparams: OP_ADD, OP_SUB, OP_AND, OP_NOT, OP_OR, OP_XOR, OP_LSL, OP_MUL.
  - State encodings: ST_EMPTY, ST_FULL, ST_MULB.
- Sub-module alu_mul_seq (WIDTH-parameterised shift-add multiplier with start/done) is instantiated only under ALU_PIPE_MUL_EN.
- Combinational op decode stays in alu_pipe.

Test Plan:
- Reset: reset_n=0 for 2 cycles, with in_valid=1 throughout. Required: out_valid=0, out=0, Z=1, in_ready=1 after release.
- ADD overflow (WIDTH=16): A=16'h7FFF, B=16'h0001, op 000, out_ready=1. Required next cycle: out=16'h8000, N=1, V=1, C=0, Z=0.
- SUB to zero then back-to-back AND:
  - Cycle 0: A=16'h1234, B=16'h1234, op 001.
  - Cycle 1: A=16'hF0F0, B=16'h0FF0, op 010.
  - Required: cycle 1 out=0, Z=1, C=1; cycle 2 out=16'h00F0, Z=0, C=0. out_valid high both cycles.
- Back-pressure: accept NOT B=16'h00FF, then hold out_ready=0 for 3 cycles while in_valid=1.
  - Required: out=16'hFF00 stable, in_ready=0 for those 3 cycles.
  - Second op is accepted only in the cycle out_ready rises.
- LSL: A=16'h0003, B=16'h0004, op 110. Required: out=16'h0030.
- With ALU_PIPE_MUL_EN: A=16'd300, B=16'd300, op 111. Required: out_valid rises 17 edges after accept, out=16'h5F90, in_ready=0 while in MULB. Asserting reset_n=0 mid-multiply returns to EMPTY, out_valid=0.
